// File: rtl/cpu_port_io.sv
// CPU 8-bit port peripheral: an RX FIFO feeds port_in and a TX FIFO drains port_out writes.
// Optional internal TX->RX loopback is enabled by defining CPU_PORT_IO_LOOPBACK_EN.
module cpu_port_io #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [7:0]  EMPTY_VAL = 8'h00
) (
    input  logic                     clock,
    input  logic                     reset,
`ifdef CPU_PORT_IO_LOOPBACK_EN
    input  logic                     loopback,
`endif
    input  logic [7:0]               port_out,
    input  logic                     cpu_wr_stb,
    output logic [7:0]               port_in,
    input  logic                     cpu_rd_stb,
    input  logic [7:0]               ext_in_data,
    input  logic                     ext_in_valid,
    output logic                     ext_in_ready,
    output logic [7:0]               ext_out_data,
    output logic                     ext_out_valid,
    input  logic                     ext_out_ready,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_ovf,
    output logic                     rx_udf,
    input  logic                     flag_clr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;

    logic       lb;
    logic       rx_full, rx_empty, tx_full, tx_empty;
    logic       rx_push, rx_pop, tx_push, tx_pop, lb_xfer;
    logic [7:0] rx_push_data;

`ifdef CPU_PORT_IO_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    always_comb begin
        rx_full  = (rx_cnt_q == CNT_FULL);
        rx_empty = (rx_cnt_q == '0);
        tx_full  = (tx_cnt_q == CNT_FULL);
        tx_empty = (tx_cnt_q == '0);

        ext_in_ready  = !rx_full && !lb;
        ext_out_valid = !tx_empty && !lb;
        ext_out_data  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
        port_in       = rx_empty ? EMPTY_VAL : rx_mem_q[rx_rd_q];

        // Loopback moves one byte per cycle from the TX head into RX.
        lb_xfer      = lb && !tx_empty && !rx_full;
        rx_push      = (ext_in_valid && ext_in_ready) || lb_xfer;
        rx_push_data = lb ? tx_mem_q[tx_rd_q] : ext_in_data;
        rx_pop       = cpu_rd_stb && !rx_empty;
        // Fullness is judged before the edge, so a same-cycle pop never rescues a push.
        tx_push      = cpu_wr_stb && !tx_full;
        tx_pop       = (ext_out_valid && ext_out_ready) || lb_xfer;

        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = rx_push_data;
            rx_wr_d           = rx_wr_q + PTR_ONE;
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + PTR_ONE;
        end
        unique case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase

        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = port_out;
            tx_wr_d           = tx_wr_q + PTR_ONE;
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + PTR_ONE;
        end
        unique case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        // Setting wins over a same-cycle clear.
        tx_ovf_d = (cpu_wr_stb && tx_full) ? 1'b1 : (flag_clr ? 1'b0 : tx_ovf_q);
        rx_udf_d = (cpu_rd_stb && rx_empty) ? 1'b1 : (flag_clr ? 1'b0 : rx_udf_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_mem_q <= '{default: '0};
            tx_mem_q <= '{default: '0};
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            rx_mem_q <= rx_mem_d;
            tx_mem_q <= tx_mem_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end

    assign rx_count = rx_cnt_q;
    assign tx_count = tx_cnt_q;
    assign tx_ovf   = tx_ovf_q;
    assign rx_udf   = rx_udf_q;

endmodule

// File: doc/cpu_port_io.md
Name: cpu_port_io

Overview:
- Peripheral at the far end of the cpu 8-bit I/O port: drives the cpu `port_in` and consumes the cpu `port_out`.
- Buffers bytes from an external producer into an RX FIFO whose head is presented on `port_in`.
- Captures cpu port writes into a TX FIFO drained to an external consumer over a valid/ready handshake.
- Sits beside `cpu` in the top level; the cpu decode supplies the read/write strobes.

Parameters:
- DEPTH, 8: entries per FIFO; power of two, ≥2.
- EMPTY_VAL, 8'h00: value driven on `port_in` while the RX FIFO is empty.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- port_out  in  8  byte written by the cpu
- cpu_wr_stb  in  1  cpu port-write strobe, one cycle per write
- port_in  out  8  RX FIFO head (EMPTY_VAL when empty), to the cpu
- cpu_rd_stb  in  1  cpu port-read strobe; pops the RX head
- ext_in_data  in  8  external producer byte
- ext_in_valid  in  1  producer valid
- ext_in_ready  out  1  RX FIFO can accept
- ext_out_data  out  8  TX FIFO head
- ext_out_valid  out  1  TX FIFO non-empty
- ext_out_ready  in  1  consumer ready
- rx_count  out  $clog2(DEPTH)+1  RX occupancy
- tx_count  out  $clog2(DEPTH)+1  TX occupancy
- tx_ovf  out  1  sticky: cpu write dropped because the TX FIFO was full
- rx_udf  out  1  sticky: cpu read while the RX FIFO was empty
- flag_clr  in  1  synchronous clear of `tx_ovf` and `rx_udf`

Behaviour:
- Reset (reset=0, async): pointers and counts 0, both FIFOs empty, `tx_ovf`=0, `rx_udf`=0.
  - Outputs during reset: `port_in`=EMPTY_VAL, `ext_in_ready`=1, `ext_out_valid`=0, `ext_out_data`=8'h00.
  - Stored FIFO contents are discarded; a reset mid-transfer loses the buffered data.
- Each FIFO: circular buffer, read/write pointers of width clog2(DEPTH) that wrap DEPTH-1→0, separate count register 0..DEPTH.
  - Full: count==DEPTH. Empty: count==0.
- RX push: `ext_in_valid` & `ext_in_ready` at a rising edge. `ext_in_ready` = !rx_full (combinational from count).
- RX pop: `cpu_rd_stb` & !rx_empty.
  - `port_in` is combinational from mem[rd_ptr]; the new head is visible in the cycle after the pop edge.
  - A byte pushed at edge N appears on `port_in` after edge N (latency 1).
- RX simultaneous push and pop:
  - Count unchanged, both pointers advance.
  - When full, the push is blocked by ready=0 even if a pop occurs in the same cycle (no same-cycle pass-through).
  - When empty, only the push occurs; the pop is treated as a read-while-empty.
- `cpu_rd_stb` while RX empty: no state change, `port_in` stays EMPTY_VAL, `rx_udf` set the next cycle.
- TX push: `cpu_wr_stb` samples `port_out` at the edge.
  - If full: the byte is dropped, `tx_ovf` set, FIFO unchanged.
  - If full and `ext_out_ready` pops in the same cycle: the push is still dropped. Full status is evaluated before the edge; this is deliberate, for determinism.
- TX pop: `ext_out_valid` & `ext_out_ready`.
  - `ext_out_data` = mem[rd_ptr] when non-empty, 8'h00 when empty.
  - Data and valid are held stable until accepted.
- TX simultaneous push and pop when neither full nor empty: count unchanged.
- Sticky flags: set has priority over `flag_clr` in the same cycle.
- Counts never exceed DEPTH and never go below 0.

Optional Feature:
- Macro: CPU_PORT_IO_LOOPBACK_EN.
- When defined: adds input `loopback` (1 bit). When `loopback`=1:
  - The TX FIFO head feeds the RX push path internally (push when TX non-empty and RX not full).
  - The external RX input is ignored: `ext_in_ready`=0.
  - `ext_out_valid`=0.
  - When `loopback` is 0 the block behaves exactly as the base design.
- When undefined: no `loopback` port; the base behaviour is unchanged.

Test Plan:
- Reset, then idle → `port_in`=8'h00, `ext_in_ready`=1, `ext_out_valid`=0, counts 0, flags 0. Assert reset mid-traffic → all return to these values immediately.
- Push 8'h0a, 8'h55 via ext_in; pulse `cpu_rd_stb` twice → `port_in` shows 0a, then 55, then 00; `rx_count` goes 2→1→0; `rx_udf` stays 0.
- Push 9 RX bytes 8'h01..8'h09 with valid held and no reads → `ext_in_ready` drops after 8 bytes, `rx_count`=8; read 8 → sequence 01..08 in order, pointers wrap correctly.
- cpu writes 8'h11..8'h19 (9 strobes) with `ext_out_ready`=0 → `tx_count`=8, `tx_ovf`=1; raise ready → 11..18 emitted, 19 never appears; `flag_clr` → `tx_ovf`=0.
- `cpu_rd_stb` with RX empty → `rx_udf`=1. Same-cycle RX push+pop at count 3 → count stays 3, order preserved.
- With CPU_PORT_IO_LOOPBACK_EN and `loopback`=1: cpu writes 8'hA5 → `port_in`=8'hA5 within 2 cycles; `ext_out_valid` stays 0.
